// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_decode_pkg
// Brief   : RV32I/RV64I opcode constants and immediate-format codes.
// Rev     : 1.0  initial release
// ============================================================================
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_pipe_if
// Brief   : Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// Rev     : 1.0  initial release
// ============================================================================
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_instr;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_imm;
  rv_decode_pkg::fmt_e       out_fmt;
  logic                      out_illegal;
  logic [31:0]               out_instr;

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
  );
endinterface
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module  : imm_decode
// Brief   : Combinational format classifier and immediate extractor.
// Rev     : 1.0  initial release
// ============================================================================
module imm_decode
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic [2:0]      funct3;

  assign funct3 = instr[14:12];

  // Size casts of signed operands replicate instr[31] up to XLEN-1.
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt = XLEN'(instr[25:20]);
    end else begin : g_shamt32
      assign shamt = XLEN'(instr[24:20]);
    end
  endgenerate

  always_comb begin
    imm     = '0;
    fmt     = FMT_ILL;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        imm = (funct3 == F3_SLLI || funct3 == F3_SRXI) ? shamt : imm_i;
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_pipe
// Brief   : Pipelined immediate generator with a 2-entry output skid buffer.
// Rev     : 1.0  initial release
// ============================================================================
module imm_gen_pipe
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_pipe_if.slave  bus
);

  localparam int DEPTH = 2;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  logic [XLEN-1:0] imm_mem   [DEPTH];
  fmt_e            fmt_mem   [DEPTH];
  logic            ill_mem   [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Ready comes only from the count register, never from out_ready.
  assign bus.in_ready  = (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i]   <= '0;
        fmt_mem[i]   <= FMT_R;
        ill_mem[i]   <= 1'b0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        imm_mem[wr_ptr]   <= dec_imm;
        fmt_mem[wr_ptr]   <= dec_fmt;
        ill_mem[wr_ptr]   <= dec_illegal;
        instr_mem[wr_ptr] <= bus.in_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_imm     = imm_mem[rd_ptr];
  assign bus.out_fmt     = fmt_mem[rd_ptr];
  assign bus.out_illegal = ill_mem[rd_ptr];
  assign bus.out_instr   = instr_mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_gen_pipe
// Brief   : Directed self-checking bench for imm_gen_pipe at XLEN=32 and 64.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded vectors: lw, beq, jal, lui, illegal, add, srai, slli, auipc, csrrw, jalr
  logic [31:0] t32_instr [11] = '{32'hFFC4A303, 32'hFE000EE3, 32'h0080006F, 32'h123452B7,
                                  32'h0000007F, 32'h00B50533, 32'h40F0D093, 32'h03F09093,
                                  32'hFFFFF097, 32'h30529073, 32'hFF808067};
  logic [31:0] t32_imm   [11] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008, 32'h12345000,
                                  32'h00000000, 32'h00000000, 32'h0000000F, 32'h0000001F,
                                  32'hFFFFF000, 32'h00000305, 32'hFFFFFFF8};
  logic [2:0]  t32_fmt   [11] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd7, 3'd0, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1};
  logic        t32_ill   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // slli 63, sw -2048, lw -4, auipc, illegal, beq -4
  logic [31:0] t64_instr [6] = '{32'h03F09093, 32'h80002023, 32'hFFC4A303, 32'hFFFFF097,
                                 32'h0000007F, 32'hFE000EE3};
  logic [63:0] t64_imm   [6] = '{64'h000000000000003F, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFFFFFFF000, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFC};
  logic [2:0]  t64_fmt   [6] = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd7, 3'd3};
  logic        t64_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_reset();
    rst_n = 1'b0;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b0;
    bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs32 in_ready=%b out_valid=%b exp 1 0", bus32.in_ready, bus32.out_valid);
    end
    checks++;
    if (bus32.out_imm !== 32'h0 || bus32.out_fmt !== 3'd0 || bus32.out_illegal !== 1'b0 ||
        bus32.out_instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_head32 imm=%h fmt=%0d ill=%b instr=%h exp all zero",
               bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_instr);
    end
    checks++;
    if (bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0 || bus64.out_imm !== 64'h0) begin
      failures++;
      $display("FAIL reset_64 in_ready=%b out_valid=%b imm=%h exp 1 0 0",
               bus64.in_ready, bus64.out_valid, bus64.out_imm);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode32();
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_instr = t32_instr[i];
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.out_imm !== t32_imm[i] || bus32.out_fmt !== t32_fmt[i] ||
          bus32.out_illegal !== t32_ill[i] || bus32.out_instr !== t32_instr[i]) begin
        failures++;
        $display("FAIL dec32[%0d] valid=%b imm=%h fmt=%0d ill=%b instr=%h exp 1 %h %0d %b %h",
                 i, bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_illegal,
                 bus32.out_instr, t32_imm[i], t32_fmt[i], t32_ill[i], t32_instr[i]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dec32_drain out_valid=%b exp 0", bus32.out_valid);
    end
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_decode64();
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus64.in_valid = 1'b1;
      bus64.in_instr = t64_instr[i];
      @(posedge clk);
      #1;
      bus64.in_valid = 1'b0;
      checks++;
      if (bus64.out_valid !== 1'b1 || bus64.out_imm !== t64_imm[i] || bus64.out_fmt !== t64_fmt[i] ||
          bus64.out_illegal !== t64_ill[i] || bus64.out_instr !== t64_instr[i]) begin
        failures++;
        $display("FAIL dec64[%0d] valid=%b imm=%h fmt=%0d ill=%b exp 1 %h %0d %b",
                 i, bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_illegal,
                 t64_imm[i], t64_fmt[i], t64_ill[i]);
      end
    end
    @(posedge clk);
    #1;
    bus64.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_instr  = 32'hFFC4A303;
    @(posedge clk); #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_one in_ready=%b out_valid=%b exp 1 1", bus32.in_ready, bus32.out_valid);
    end
    bus32.in_instr = 32'h0080006F;
    @(posedge clk); #1;
    bus32.in_instr = 32'h123452B7;
    checks++;
    if (bus32.in_ready !== 1'b0 || bus32.out_instr !== 32'hFFC4A303) begin
      failures++;
      $display("FAIL bp_full in_ready=%b head=%h exp 0 ffc4a303", bus32.in_ready, bus32.out_instr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus32.in_ready !== 1'b0 || bus32.out_instr !== 32'hFFC4A303 || bus32.out_imm !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL bp_hold in_ready=%b head=%h imm=%h exp 0 ffc4a303 fffffffc",
               bus32.in_ready, bus32.out_instr, bus32.out_imm);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1 || bus32.out_instr !== 32'h0080006F ||
        bus32.out_imm !== 32'h00000008) begin
      failures++;
      $display("FAIL bp_pop1 in_ready=%b valid=%b head=%h imm=%h exp 1 1 0080006f 00000008",
               bus32.in_ready, bus32.out_valid, bus32.out_instr, bus32.out_imm);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_instr !== 32'h123452B7 || bus32.out_imm !== 32'h12345000 ||
        bus32.out_fmt !== 3'd4) begin
      failures++;
      $display("FAIL bp_pop2 valid=%b head=%h imm=%h fmt=%0d exp 1 123452b7 12345000 4",
               bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_fmt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_empty valid=%b in_ready=%b exp 0 1", bus32.out_valid, bus32.in_ready);
    end
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_instr  = 32'hFFC4A303;
    @(posedge clk); #1;
    bus32.in_instr = 32'h0080006F;
    @(posedge clk); #1;
    bus32.flush     = 1'b1;
    bus32.out_ready = 1'b1;
    bus32.in_instr  = 32'h123452B7;
    @(posedge clk); #1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full valid=%b in_ready=%b exp 0 1", bus32.out_valid, bus32.in_ready);
    end
    // A push that coincides with flush while there is room must still be dropped.
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'hFFC4A303;
    @(posedge clk); #1;
    bus32.flush    = 1'b1;
    bus32.in_instr = 32'h123452B7;
    @(posedge clk); #1;
    bus32.flush    = 1'b0;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_push valid=%b exp 0", bus32.out_valid);
    end
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'hFE000EE3;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_instr !== 32'hFE000EE3 || bus32.out_fmt !== 3'd3) begin
      failures++;
      $display("FAIL flush_after valid=%b head=%h fmt=%0d exp 1 fe000ee3 3",
               bus32.out_valid, bus32.out_instr, bus32.out_fmt);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_instr  = 32'hFFC4A303;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_imm !== 32'h0 ||
        bus32.out_instr !== 32'h0 || bus32.out_fmt !== 3'd0) begin
      failures++;
      $display("FAIL async_rst valid=%b in_ready=%b imm=%h instr=%h fmt=%0d exp 0 1 0 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_instr, bus32.out_fmt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h0080006F;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_instr !== 32'h0080006F) begin
      failures++;
      $display("FAIL rst_first_push valid=%b head=%h exp 1 0080006f", bus32.out_valid, bus32.out_instr);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode32();
    test_decode64();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
